// File: rtl/mul_pkg.sv
// Shared opcode encodings and the S1 payload layout for the pipelined multiply unit.
package mul_pkg;

  localparam int MUL_XLEN  = 32;
  localparam int MUL_TAG_W = 5;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  // Operands are widened by one bit so every RV32M signedness mix fits a signed multiply.
  typedef struct packed {
    logic [1:0]                op;
    logic signed [MUL_XLEN:0]  a_ext;
    logic signed [MUL_XLEN:0]  b_ext;
    logic [MUL_TAG_W-1:0]      tag;
  } s1_payload_t;

endpackage

// File: rtl/mul_sext_core.sv
// Combinational signed WxW multiplier producing the full 2W-bit product.
module mul_sext_core #(
  parameter int W = 33
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] prod
);

  logic signed [2*W-1:0] a_wide;
  logic signed [2*W-1:0] b_wide;

  assign a_wide = {{W{a[W-1]}}, a};
  assign b_wide = {{W{b[W-1]}}, b};
  assign prod   = a_wide * b_wide;

endmodule

// File: rtl/mul_pipe_unit.sv
// Two-stage RV32M multiply unit: S1 captures sign-extended operands, S2 holds the selected product half.
module mul_pipe_unit
  import mul_pkg::*;
#(
  parameter int XLEN  = MUL_XLEN,
  parameter int TAG_W = MUL_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int W = XLEN + 1;

  s1_payload_t           pl_p0;
  s1_payload_t           pl_p1;
  logic                  vld_p1;
  logic                  vld_p2;
  logic [XLEN-1:0]       result_p2;
  logic [TAG_W-1:0]      tag_p2;
  logic signed [2*W-1:0] prod_p1;
  logic                  s2_free;
  logic                  accept;
  logic                  adv;
  logic                  unused_prod_hi;

  function automatic logic [XLEN-1:0] sel_half(input logic [1:0] op,
                                               input logic signed [2*W-1:0] p);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign s2_free  = !vld_p2 || out_ready;
  assign in_ready = !flush && (!vld_p1 || s2_free);
  assign accept   = in_valid && in_ready;
  assign adv      = vld_p1 && s2_free && !flush;

  // MULHU treats rs1 as unsigned; only MUL/MULH treat rs2 as signed.
  always_comb begin
    pl_p0       = '0;
    pl_p0.op    = in_op;
    pl_p0.tag   = in_tag;
    pl_p0.a_ext = {(in_op != OP_MULHU) && in_a[XLEN-1], in_a};
    pl_p0.b_ext = {((in_op == OP_MUL) || (in_op == OP_MULH)) && in_b[XLEN-1], in_b};
  end

  // ---- S1 -> S2: multiplier core ----
  mul_sext_core #(.W(W)) u_core (
    .a    (pl_p1.a_ext),
    .b    (pl_p1.b_ext),
    .prod (prod_p1)
  );

  assign unused_prod_hi = ^prod_p1[2*W-1:2*XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      pl_p1     <= '0;
      result_p2 <= '0;
      tag_p2    <= '0;
    end else begin
      if (flush) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        if (accept)
          vld_p1 <= 1'b1;
        else if (adv)
          vld_p1 <= 1'b0;
        if (s2_free)
          vld_p2 <= vld_p1;
      end
      if (accept)
        pl_p1 <= pl_p0;
      if (adv) begin
        result_p2 <= sel_half(pl_p1.op, prod_p1);
        tag_p2    <= pl_p1.tag;
      end
    end
  end

  // ---- S2: output register ----
  assign out_valid  = vld_p2;
  assign out_result = result_p2;
  assign out_tag    = tag_p2;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed and randomized bench for mul_pipe_unit against a 64-bit arithmetic reference.
module tb_mul_pipe_unit;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  int vecs   = 0;
  int miscmp = 0;

  mul_pipe_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     p;
    case (op)
      OP_MUL:    p = ua * ub;
      OP_MULH:   p = sa * sb;
      OP_MULHSU: p = sa * longint'(ub);
      default:   p = ua * ub;
    endcase
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h required %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  logic [1:0]  sw_op  [4] = '{OP_MULH, OP_MULHU, OP_MULHSU, OP_MULH};
  logic [31:0] sw_a   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] sw_b   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] sw_exp [4] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};

  logic [31:0] exp_q[$];
  logic [4:0]  tag_q[$];

  initial begin
    int accepted;
    int cyc;
    logic hs_in;
    logic hs_out;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = OP_MUL; in_a = '0; in_b = '0; in_tag = '0;
    tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // Basic latency
    out_ready = 1'b1;
    drive(OP_MUL, 32'd3, 32'd5, 5'd7);
    tick();
    in_valid = 1'b0;
    chk("lat_not_yet", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_result", out_result, 32'h0000000F);
    chk("lat_tag", out_tag, 7);
    tick();
    chk("lat_single", out_valid, 0);

    // Back-to-back signedness sweep
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(sw_op[i], sw_a[i], sw_b[i], 5'(i + 1));
      else in_valid = 1'b0;
      tick();
      if (i >= 1 && i <= 4) begin
        chk("sweep_valid", out_valid, 1);
        chk("sweep_result", out_result, sw_exp[i-1]);
        chk("sweep_tag", out_tag, 64'(i));
      end else begin
        chk("sweep_idle", out_valid, 0);
      end
    end

    // Backpressure
    out_ready = 1'b0;
    drive(OP_MUL, 32'd7, 32'd9, 5'd10);
    chk("bp_rdy_a", in_ready, 1);
    tick();
    drive(OP_MULHU, 32'hFFFFFFFF, 32'd2, 5'd11);
    chk("bp_rdy_b", in_ready, 1);
    tick();
    drive(OP_MULH, 32'hFFFFFFFE, 32'd3, 5'd12);
    chk("bp_rdy_c", in_ready, 0);
    chk("bp_valid_a", out_valid, 1);
    chk("bp_result_a", out_result, 63);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold_result", out_result, 63);
      chk("bp_hold_tag", out_tag, 10);
      chk("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", in_ready, 1);
    chk("bp_drain_a", out_result, 63);
    tick();
    in_valid = 1'b0;
    chk("bp_drain_b", out_result, 1);
    chk("bp_drain_b_tag", out_tag, 11);
    tick();
    chk("bp_drain_c", out_result, 32'hFFFFFFFF);
    chk("bp_drain_c_tag", out_tag, 12);
    tick();
    chk("bp_no_dup", out_valid, 0);

    // Flush with both stages full
    out_ready = 1'b0;
    drive(OP_MUL, 32'd2, 32'd2, 5'd13);
    tick();
    drive(OP_MUL, 32'd3, 32'd3, 5'd14);
    tick();
    drive(OP_MUL, 32'd4, 32'd4, 5'd15);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_rdy", in_ready, 0);
    chk("flush_full", out_valid, 1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_cleared", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_stale", out_valid, 0);
    end
    drive(OP_MULHU, 32'h00010000, 32'h00010000, 5'd16);
    tick();
    in_valid = 1'b0;
    tick();
    chk("flush_after_valid", out_valid, 1);
    chk("flush_after_result", out_result, 1);
    chk("flush_after_tag", out_tag, 16);
    tick();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    drive(OP_MUL, 32'd5, 32'd6, 5'd17);
    tick();
    drive(OP_MUL, 32'd7, 32'd8, 5'd18);
    tick();
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_stale", out_valid, 0);
      chk("rst_rdy", in_ready, 1);
    end

    // Randomized traffic against the reference model
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom);
      in_a      = $urandom;
      in_b      = $urandom;
      if ($urandom_range(0, 7) == 0) in_a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) in_b = 32'hFFFFFFFF;
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("rand_spurious", out_valid, 0);
        else begin
          chk("rand_result", out_result, exp_q[0]);
          chk("rand_tag", out_tag, tag_q[0]);
        end
      end
      if (hs_out && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
      end
      if (hs_in) begin
        exp_q.push_back(ref_mul(in_op, in_a, in_b));
        tag_q.push_back(in_tag);
        accepted++;
      end
      tick();
      cyc++;
    end
    if (accepted < 10000) chk("rand_timeout", accepted, 10000);

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("drain_spurious", out_valid, 0);
        else begin
          chk("drain_result", out_result, exp_q[0]);
          chk("drain_tag", out_tag, tag_q[0]);
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
        end
      end
      tick();
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
